// File: rtl/piso_tx_pkg.sv
// Shared constants for the two-requester PISO transmit scheduler:
// FSM state encoding, source ids and the round-robin grant rule.
package piso_tx_pkg;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_SHIFT = 2'd1;
  localparam logic [1:0] ST_GAP   = 2'd2;

  localparam logic SRC_REQ0 = 1'b0;
  localparam logic SRC_REQ1 = 1'b1;

  // A lone requester always wins; on a tie the one not served last wins.
  function automatic logic pick_grant(input logic v0, input logic v1, input logic last);
    if (v0 && v1) return ~last;
    else if (v1) return SRC_REQ1;
    else return SRC_REQ0;
  endfunction

endpackage

// File: rtl/piso_shifter.sv
// Parallel-in/serial-out shifter, MSB first, zero fill.
// Load has priority over shift; otherwise the word holds.
module piso_shifter #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic             shift_en,
  input  logic [WIDTH-1:0] parallel_in,
  output logic             serial_out
);

  logic [WIDTH-1:0] r_shift;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_shift <= '0;
    end else if (load) begin
      r_shift <= parallel_in;
    end else if (shift_en) begin
      r_shift <= {r_shift[WIDTH-2:0], 1'b0};
    end
  end

  assign serial_out = r_shift[WIDTH-1];

endmodule

// File: rtl/piso_tx_arbiter.sv
// Round-robin scheduler for two word producers sharing one serial link.
// A granted word is loaded in IDLE, shifted out over WIDTH cycles, then GAP idles.
module piso_tx_arbiter
  import piso_tx_pkg::*;
#(
  parameter int WIDTH      = 4,
  parameter int GAP_CYCLES = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             req0_valid,
  input  logic [WIDTH-1:0] req0_data,
  output logic             req0_ready,
  input  logic             req1_valid,
  input  logic [WIDTH-1:0] req1_data,
  output logic             req1_ready,
  output logic             serial_out,
  output logic             serial_valid,
  output logic             serial_src,
  output logic             busy
);

  localparam int BW = $clog2(WIDTH + 1);
  localparam int GW = (GAP_CYCLES > 0) ? $clog2(GAP_CYCLES + 1) : 1;

  logic [1:0]       r_state;
  logic [1:0]       w_state_next;
  logic             r_last_grant;
  logic             r_src;
  logic [BW-1:0]    r_bit_cnt;
  logic [GW-1:0]    r_gap_cnt;
  logic             w_any_valid;
  logic             w_grant;
  logic             w_xfer;
  logic             w_last_bit;
  logic             w_shift_en;
  logic             w_shifter_msb;
  logic [WIDTH-1:0] w_load_data;

  assign w_any_valid = req0_valid | req1_valid;
  assign w_grant     = pick_grant(req0_valid, req1_valid, r_last_grant);
  // Ready is combinational, so the transfer must also be masked by reset.
  assign w_xfer      = !reset && (r_state == ST_IDLE) && w_any_valid;
  assign w_load_data = (w_grant == SRC_REQ1) ? req1_data : req0_data;
  assign w_shift_en  = (r_state == ST_SHIFT);
  assign w_last_bit  = w_shift_en && (r_bit_cnt == BW'(1));

  always_ff @(posedge clk) begin
    if (reset) r_state <= ST_IDLE;
    else       r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      ST_IDLE:  if (w_any_valid) w_state_next = ST_SHIFT;
      ST_SHIFT: if (r_bit_cnt == BW'(1)) w_state_next = (GAP_CYCLES > 0) ? ST_GAP : ST_IDLE;
      ST_GAP:   if (r_gap_cnt == GW'(1)) w_state_next = ST_IDLE;
      default:  w_state_next = ST_IDLE;
    endcase
  end

  always_comb begin
    req0_ready   = w_xfer && (w_grant == SRC_REQ0);
    req1_ready   = w_xfer && (w_grant == SRC_REQ1);
    serial_valid = (r_state == ST_SHIFT);
    serial_out   = serial_valid & w_shifter_msb;
    serial_src   = r_src;
    busy         = (r_state != ST_IDLE);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_bit_cnt    <= '0;
      r_gap_cnt    <= '0;
      r_last_grant <= SRC_REQ1;
      r_src        <= SRC_REQ0;
    end else begin
      if (w_xfer) begin
        r_bit_cnt    <= BW'(WIDTH);
        r_last_grant <= w_grant;
        r_src        <= w_grant;
      end else if (w_shift_en) begin
        r_bit_cnt <= r_bit_cnt - BW'(1);
      end
      if (w_last_bit) begin
        r_gap_cnt <= GW'(GAP_CYCLES);
      end else if (r_state == ST_GAP) begin
        r_gap_cnt <= r_gap_cnt - GW'(1);
      end
    end
  end

  piso_shifter #(.WIDTH(WIDTH)) u_shifter (
    .clk        (clk),
    .reset      (reset),
    .load       (w_xfer),
    .shift_en   (w_shift_en),
    .parallel_in(w_load_data),
    .serial_out (w_shifter_msb)
  );

endmodule

// File: tb/tb_piso_tx_arbiter.sv
// Bench for piso_tx_arbiter: instance 0 is WIDTH=4/GAP=1, instance 1 is WIDTH=8/GAP=0.
// A frame-level model predicts every output each cycle; directed steps pin literal values.
module tb_piso_tx_arbiter;

  logic       clk = 1'b0;
  logic [1:0] rst = 2'b11;
  logic [1:0] v0 = 2'b00;
  logic [1:0] v1 = 2'b00;
  logic [7:0] d0 [2];
  logic [7:0] d1 [2];
  logic [1:0] rdy0, rdy1, so, sv, ssrc, bsy;

  int checks   = 0;
  int failures = 0;

  logic [7:0] m_data [2];
  int         m_rem  [2];
  logic [1:0] m_last = 2'b11;
  logic [1:0] m_src  = 2'b00;
  logic [1:0] m_ok   = 2'b00;
  logic [1:0] m_hs0  = 2'b00;
  logic [1:0] m_hs1  = 2'b00;

  always #5 clk = ~clk;

  piso_tx_arbiter #(.WIDTH(4), .GAP_CYCLES(1)) dut_a (
    .clk(clk), .reset(rst[0]),
    .req0_valid(v0[0]), .req0_data(d0[0][3:0]), .req0_ready(rdy0[0]),
    .req1_valid(v1[0]), .req1_data(d1[0][3:0]), .req1_ready(rdy1[0]),
    .serial_out(so[0]), .serial_valid(sv[0]), .serial_src(ssrc[0]), .busy(bsy[0])
  );

  piso_tx_arbiter #(.WIDTH(8), .GAP_CYCLES(0)) dut_b (
    .clk(clk), .reset(rst[1]),
    .req0_valid(v0[1]), .req0_data(d0[1]), .req0_ready(rdy0[1]),
    .req1_valid(v1[1]), .req1_data(d1[1]), .req1_ready(rdy1[1]),
    .serial_out(so[1]), .serial_valid(sv[1]), .serial_src(ssrc[1]), .busy(bsy[1])
  );

  function automatic int wid(input int i);
    return (i == 0) ? 4 : 8;
  endfunction

  function automatic int gap(input int i);
    return (i == 0) ? 1 : 0;
  endfunction

  task automatic chk(input string nm, input int i, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s inst%0d got=%b expected=%b at t=%0t", nm, i, act, exp, $time);
    end
  endtask

  // Model: a frame is WIDTH data bits followed by GAP idle cycles; the
  // scheduler is free (IDLE) exactly when no frame cycles remain.
  always @(negedge clk) begin
    for (int i = 0; i < 2; i++) begin
      logic g, idle, e_r0, e_r1, e_sv, e_so;
      int   pos;
      g    = (v0[i] && v1[i]) ? ~m_last[i] : v1[i];
      idle = (m_rem[i] == 0);
      e_r0 = !rst[i] && idle && v0[i] && !g;
      e_r1 = !rst[i] && idle && v1[i] && g;
      e_sv = 1'b0;
      e_so = 1'b0;
      if (!idle) begin
        pos = wid(i) + gap(i) - m_rem[i];
        if (pos < wid(i)) begin
          e_sv = 1'b1;
          e_so = m_data[i][wid(i) - 1 - pos];
        end
      end
      if (m_ok[i]) begin
        chk("req0_ready", i, rdy0[i], e_r0);
        chk("req1_ready", i, rdy1[i], e_r1);
        chk("serial_valid", i, sv[i], e_sv);
        chk("serial_out", i, so[i], e_so);
        chk("serial_src", i, ssrc[i], m_src[i]);
        chk("busy", i, bsy[i], !idle);
      end
      m_hs0[i] = e_r0;
      m_hs1[i] = e_r1;
      if (rst[i]) begin
        m_rem[i]  = 0;
        m_last[i] = 1'b1;
        m_src[i]  = 1'b0;
        m_ok[i]   = 1'b1;
      end else if (!idle) begin
        m_rem[i] = m_rem[i] - 1;
      end else if (v0[i] || v1[i]) begin
        m_data[i] = g ? d1[i] : d0[i];
        m_rem[i]  = wid(i) + gap(i);
        m_last[i] = g;
        m_src[i]  = g;
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_reset(input int i);
    rst[i] = 1'b1;
    step();
    rst[i] = 1'b0;
  endtask

  task automatic expect_bits(input int i, input int w, input logic [7:0] bits, input logic src);
    for (int k = 0; k < w; k++) begin
      @(negedge clk);
      chk("lit_valid", i, sv[i], 1'b1);
      chk("lit_bit", i, so[i], bits[w - 1 - k]);
      chk("lit_src", i, ssrc[i], src);
      chk("lit_rdy0_frame", i, rdy0[i], 1'b0);
      chk("lit_rdy1_frame", i, rdy1[i], 1'b0);
      step();
    end
  endtask

  initial begin
    int hs;
    d0[0] = 8'h00; d0[1] = 8'h00; d1[0] = 8'h00; d1[1] = 8'h00;
    repeat (3) step();
    @(negedge clk);
    chk("reset_busy", 0, bsy[0], 1'b0);
    chk("reset_valid", 1, sv[1], 1'b0);
    step();
    rst = 2'b00;

    // 1: single req0 word 1011, then one gap cycle
    v0[0] = 1'b1; d0[0] = 8'h0B;
    @(negedge clk);
    chk("t1_ready", 0, rdy0[0], 1'b1);
    step();
    v0[0] = 1'b0;
    expect_bits(0, 4, 8'h0B, 1'b0);
    @(negedge clk);
    chk("t1_gap_valid", 0, sv[0], 1'b0);
    chk("t1_gap_busy", 0, bsy[0], 1'b1);
    step();
    @(negedge clk);
    chk("t1_idle_busy", 0, bsy[0], 1'b0);
    step();

    // 2: tie after reset goes to req0, req1 waits for the next IDLE
    pulse_reset(0);
    v0[0] = 1'b1; d0[0] = 8'h0C; v1[0] = 1'b1; d1[0] = 8'h03;
    @(negedge clk);
    chk("t2_rdy0", 0, rdy0[0], 1'b1);
    chk("t2_rdy1", 0, rdy1[0], 1'b0);
    step();
    v0[0] = 1'b0;
    expect_bits(0, 4, 8'h0C, 1'b0);
    @(negedge clk);
    chk("t2_gap_rdy1", 0, rdy1[0], 1'b0);
    step();
    @(negedge clk);
    chk("t2_rdy1_next", 0, rdy1[0], 1'b1);
    step();
    v1[0] = 1'b0;
    expect_bits(0, 4, 8'h03, 1'b1);
    step();

    // 3: both continuously valid -> alternating grants every 6 cycles
    pulse_reset(0);
    v0[0] = 1'b1; v1[0] = 1'b1;
    for (int t = 0; t < 24; t++) begin
      @(negedge clk);
      chk("t3_rdy0", 0, rdy0[0], (t % 12) == 0);
      chk("t3_rdy1", 0, rdy1[0], (t % 12) == 6);
      step();
      if (m_hs0[0]) d0[0] = 8'($urandom);
      if (m_hs1[0]) d1[0] = 8'($urandom);
    end
    v0[0] = 1'b0; v1[0] = 1'b0;
    repeat (6) step();

    // 4: only req1 valid, word 1111, served every frame
    pulse_reset(0);
    v1[0] = 1'b1; d1[0] = 8'h0F;
    hs = 0;
    for (int t = 0; t < 18; t++) begin
      @(negedge clk);
      if (rdy1[0]) hs++;
      step();
    end
    checks++;
    if (hs != 3) begin
      failures++;
      $display("FAIL t4_handshakes inst0 got=%0d expected=3", hs);
    end
    v1[0] = 1'b0;
    repeat (6) step();

    // 5: reset during the second bit of a req1 frame
    v1[0] = 1'b1; d1[0] = 8'h0F;
    step();
    v1[0] = 1'b0;
    step();
    rst[0] = 1'b1;
    @(negedge clk);
    chk("t5_second_bit", 0, sv[0], 1'b1);
    step();
    rst[0] = 1'b0;
    v0[0] = 1'b1; v1[0] = 1'b1;
    @(negedge clk);
    chk("t5_valid", 0, sv[0], 1'b0);
    chk("t5_out", 0, so[0], 1'b0);
    chk("t5_busy", 0, bsy[0], 1'b0);
    chk("t5_src", 0, ssrc[0], 1'b0);
    chk("t5_tie_rdy0", 0, rdy0[0], 1'b1);
    chk("t5_tie_rdy1", 0, rdy1[0], 1'b0);
    step();
    v0[0] = 1'b0; v1[0] = 1'b0;
    repeat (6) step();

    // 6: WIDTH=8, no gap, next handshake right after the last bit
    v0[1] = 1'b1; d0[1] = 8'hA5;
    @(negedge clk);
    chk("t6_rdy0", 1, rdy0[1], 1'b1);
    step();
    v0[1] = 1'b0; v1[1] = 1'b1; d1[1] = 8'h3C;
    expect_bits(1, 8, 8'hA5, 1'b0);
    @(negedge clk);
    chk("t6_rdy1_after_last", 1, rdy1[1], 1'b1);
    chk("t6_idle_busy", 1, bsy[1], 1'b0);
    step();
    v1[1] = 1'b0;
    repeat (10) step();

    // Random traffic on both instances with occasional resets
    for (int c = 0; c < 1500; c++) begin
      for (int i = 0; i < 2; i++) begin
        rst[i] = ($urandom_range(0, 79) == 0);
        if (!v0[i] || m_hs0[i]) begin
          v0[i] = ($urandom_range(0, 2) != 0);
          d0[i] = 8'($urandom);
        end
        if (!v1[i] || m_hs1[i]) begin
          v1[i] = ($urandom_range(0, 2) != 0);
          d1[i] = 8'($urandom);
        end
      end
      step();
    end
    rst = 2'b00; v0 = 2'b00; v1 = 2'b00;
    repeat (12) step();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/piso_tx_arbiter.md
Name: piso_tx_arbiter

Overview:
Two-requester transmit scheduler that shares one parallel-in/serial-out shifter. Each requester offers a WIDTH-bit word over a valid/ready handshake. A round-robin arbiter grants one requester, and the block loads that word into the shifter and sends it MSB-first, one bit per clock. The output is framed by serial_valid and tagged with the source id. It sits between the word-level producers and the serial link.

Parameters:
WIDTH, 4, data word width in bits (>= 2)
GAP_CYCLES, 1, idle cycles inserted after each frame before the next grant (>= 0)

Ports:
clk  input  1  system clock, all logic on rising edge
reset  input  1  synchronous, active-high reset
req0_valid  input  1  requester 0 has a word
req0_data  input  WIDTH  requester 0 word
req0_ready  output  1  requester 0 word accepted this cycle
req1_valid  input  1  requester 1 has a word
req1_data  input  WIDTH  requester 1 word
req1_ready  output  1  requester 1 word accepted this cycle
serial_out  output  1  serial data, MSB first
serial_valid  output  1  high while serial_out carries a frame bit
serial_src  output  1  id of the requester owning the current frame
busy  output  1  high when the state is not IDLE

Behaviour:
- Clock and reset: one clock, clk. Reset is synchronous and active-high; it dominates all other inputs.
- Reset values: state=IDLE, shift register=0, bit counter=0, gap counter=0, last_grant=1 (so requester 0 wins the first tie). serial_out=0, serial_valid=0, serial_src=0, busy=0.
- Ready during reset: reqX_ready is forced to 0 in any cycle where reset=1.
- States: IDLE, SHIFT, GAP.
- IDLE, arbitration: if exactly one reqX_valid is high, that requester is granted. If both are high, the requester other than last_grant is granted.
- IDLE, handshake: reqX_ready is combinational, high only for the granted requester in IDLE. A transfer happens when valid and ready are both high in that cycle (cycle N).
- IDLE, on transfer: the shifter loads reqX_data, serial_src<=X, last_grant<=X, bit counter<=WIDTH, state goes to SHIFT.
- Requester rules: a requester holds valid and data stable until ready. If valid drops without a handshake, nothing is recorded and last_grant is unchanged.
- SHIFT:
  - serial_out = shifter MSB; serial_valid=1.
  - The shifter shifts left with zero fill every cycle; the bit counter decrements.
  - The first bit appears in cycle N+1 and the last bit in cycle N+WIDTH.
  - After the last bit, state goes to GAP if GAP_CYCLES>0, else to IDLE.
- GAP: lasts exactly GAP_CYCLES cycles with serial_valid=0 and serial_out=0, then state returns to IDLE.
- Outside SHIFT: serial_valid=0 and serial_out=0. serial_src holds its last value.
- Frame spacing: the minimum frame period is 1 (IDLE handshake) + WIDTH + GAP_CYCLES cycles. Frames are never back-to-back without at least one serial_valid=0 cycle.
- Request changes mid-frame: requests arriving during SHIFT or GAP get ready=0 and are arbitrated in the next IDLE.
- Reset mid-frame: on the next edge the frame is abandoned, all outputs return to reset values, and last_grant=1. No partial frame resumes afterwards.
- Shifter priority: load > shift > hold. The load and shift enables are never asserted together.
- Bit counter width: $clog2(WIDTH+1). Gap counter width: $clog2(GAP_CYCLES+1), minimum 1 bit.

Decomposition:
- Shared package piso_tx_pkg:
  - state encoding localparams ST_IDLE=2'd0, ST_SHIFT=2'd1, ST_GAP=2'd2
  - source id constants SRC_REQ0=1'b0, SRC_REQ1=1'b1
- One sub-module, piso_shifter #(WIDTH):
  - ports: clk, reset (synchronous), load, shift_en, parallel_in[WIDTH-1:0], serial_out (= MSB)
  - zero-fill left shift
- Arbiter, FSM and counters live in the top module.

Test Plan:
1. Reset, then req0_valid with req0_data=4'b1011 -> req0_ready=1 in cycle N. Cycles N+1..N+4: serial_out=1,0,1,1 with serial_valid=1 and serial_src=0. Cycle N+5: serial_valid=0 (GAP). Ready again possible at N+6.
2. After reset, both valid together, req0=4'b1100 and req1=4'b0011 -> req0 served first (bits 1100, src 0). req1_ready stays 0 until the next IDLE, then bits 0011 with src 1.
3. Both valid continuously for 4 frames -> grant order 0,1,0,1. Frame period is 6 cycles with the default parameters.
4. Only req1 valid, repeatedly, data 4'b1111 -> req1 served every frame with src 1. No starvation from the idle req0.
5. Reset asserted during the 2nd bit of a req1 frame -> next cycle serial_valid=0, serial_out=0, busy=0, serial_src=0. A following tie grants req0 first.
6. Instance WIDTH=8, GAP_CYCLES=0, req0_data=8'hA5 -> bits 1,0,1,0,0,1,0,1, then IDLE immediately. A new handshake is accepted in the cycle after the last bit.
